// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and receiver state encoding, shared by the
// generator, the capture block and the frame checker.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int CW        = 11;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    typedef enum logic [1:0] {
        HSEARCH = 2'd0,
        VSEARCH = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one active-low sync line on the pixel strobe and flags the
// high-to-low transition between the two most recent samples.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_n,
    output logic sync_fall
);

    logic cur_r;
    logic prev_r;

    // Two-sample history; reset to the idle (deasserted) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r  <= 1'b1;
            prev_r <= 1'b1;
        end else if (pix_en) begin
            prev_r <= cur_r;
            cur_r  <= sync_n;
        end
    end

    assign sync_fall = prev_r & ~cur_r;

endmodule

// File: rtl/vga_rx_capture.sv
// VGA receiver: locks to hsync/vsync, recovers pixel coordinates and
// reports line/frame length errors. Two-stage pipeline driven by pix_en.
module vga_rx_capture #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int CW        = vga_timing_pkg::CW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       vga_hsync_n,
    input  logic       vga_vsync_n,
    input  logic       vga_r,
    input  logic       vga_g,
    input  logic       vga_b,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       err_hlen,
    output logic       err_vlen
);

    import vga_timing_pkg::rx_state_e;
    import vga_timing_pkg::HSEARCH;
    import vga_timing_pkg::VSEARCH;
    import vga_timing_pkg::LOCKED;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_BEG = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_END = CW'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [CW-1:0] V_BEG = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_END = CW'(V_SYNC + V_BP + V_VISIBLE);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
        if (val == {CW{1'b1}}) begin
            return val;
        end else begin
            return val + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    logic          en_d_r;
    logic [2:0]    rgb_r;
    logic          hs_fall_s;
    logic          vs_fall_s;
    rx_state_e     state_r;
    rx_state_e     state_nxt_s;
    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] h_cnt_nxt_s;
    logic [CW-1:0] v_cnt_r;
    logic [CW-1:0] v_cnt_nxt_s;
    logic [CW-1:0] hx_s;
    logic [CW-1:0] vy_s;
    logic          vs_pend_r;
    logic          vs_pend_nxt_s;
    logic          hlen_ok_r;
    logic          hlen_ok_nxt_s;
    logic          hlen_bad_s;
    logic          vlen_bad_s;
    logic          err_hlen_s;
    logic          err_vlen_s;
    logic          lock_nxt_s;
    logic          vis_s;

    vga_sync_edge u_hsync (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .sync_n    (vga_hsync_n),
        .sync_fall (hs_fall_s)
    );

    vga_sync_edge u_vsync (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .sync_n    (vga_vsync_n),
        .sync_fall (vs_fall_s)
    );

    // Stage 1: colour sample plus a one-clk-delayed strobe that fires stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d_r <= 1'b0;
            rgb_r  <= 3'b000;
        end else begin
            en_d_r <= pix_en;
            if (pix_en) begin
                rgb_r <= {vga_r, vga_g, vga_b};
            end
        end
    end

    assign hlen_bad_s = (32'(h_cnt_r) + 32'd1) != 32'(H_TOT);
    assign vlen_bad_s = (32'(v_cnt_r) + 32'd1) != 32'(V_TOT);

    // Counters, pending-vsync flag and lock FSM next state.
    always_comb begin
        state_nxt_s   = state_r;
        h_cnt_nxt_s   = h_cnt_r;
        v_cnt_nxt_s   = v_cnt_r;
        vs_pend_nxt_s = vs_pend_r;
        hlen_ok_nxt_s = hlen_ok_r;
        err_hlen_s    = 1'b0;
        err_vlen_s    = 1'b0;
        if (en_d_r) begin
            // A vsync edge earlier in the line is remembered until the next hsync.
            if (hs_fall_s) begin
                h_cnt_nxt_s   = {CW{1'b0}};
                v_cnt_nxt_s   = (vs_fall_s || vs_pend_r) ? {CW{1'b0}} : sat_inc(v_cnt_r);
                vs_pend_nxt_s = 1'b0;
            end else begin
                h_cnt_nxt_s   = sat_inc(h_cnt_r);
                vs_pend_nxt_s = vs_pend_r | vs_fall_s;
            end
            case (state_r)
                HSEARCH: begin
                    if (hs_fall_s) begin
                        state_nxt_s   = VSEARCH;
                        hlen_ok_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s   = HSEARCH;
                    end
                end
                VSEARCH: begin
                    if (hs_fall_s && hlen_bad_s) begin
                        err_hlen_s  = 1'b1;
                        state_nxt_s = HSEARCH;
                    end else if (vs_fall_s && (hs_fall_s || hlen_ok_r)) begin
                        state_nxt_s = LOCKED;
                    end else begin
                        hlen_ok_nxt_s = hlen_ok_r | hs_fall_s;
                    end
                end
                LOCKED: begin
                    err_hlen_s = hs_fall_s & hlen_bad_s;
                    err_vlen_s = vs_fall_s & vlen_bad_s;
                    if (err_hlen_s || err_vlen_s) begin
                        state_nxt_s = HSEARCH;
                    end else begin
                        state_nxt_s = LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = HSEARCH;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign lock_nxt_s = (state_nxt_s == LOCKED);
    assign vis_s = lock_nxt_s
                && (h_cnt_nxt_s >= H_BEG) && (h_cnt_nxt_s < H_END)
                && (v_cnt_nxt_s >= V_BEG) && (v_cnt_nxt_s < V_END);
    assign hx_s = h_cnt_nxt_s - H_BEG;
    assign vy_s = v_cnt_nxt_s - V_BEG;

    // Stage 2: state and registered outputs; coordinates hold between pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HSEARCH;
            h_cnt_r     <= {CW{1'b0}};
            v_cnt_r     <= {CW{1'b0}};
            vs_pend_r   <= 1'b0;
            hlen_ok_r   <= 1'b0;
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 3'b000;
        end else begin
            state_r     <= state_nxt_s;
            h_cnt_r     <= h_cnt_nxt_s;
            v_cnt_r     <= v_cnt_nxt_s;
            vs_pend_r   <= vs_pend_nxt_s;
            hlen_ok_r   <= hlen_ok_nxt_s;
            locked      <= lock_nxt_s;
            pix_valid   <= en_d_r & vis_s;
            line_start  <= en_d_r & hs_fall_s & lock_nxt_s;
            frame_start <= en_d_r & vs_fall_s & lock_nxt_s;
            err_hlen    <= err_hlen_s;
            err_vlen    <= err_vlen_s;
            if (en_d_r && vis_s) begin
                pix_x   <= hx_s[9:0];
                pix_y   <= vy_s[9:0];
                pix_rgb <= rgb_r;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture using a reduced timing (16x9 total,
// 8x4 visible) so that many whole frames fit in a short run.
module tb_vga_rx_capture;

    localparam int HV  = 8;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VV  = 4;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HV + HFP + HSY + HBP;   // 16
    localparam int VT  = VV + VFP + VSY + VBP;   // 9
    localparam int HST = HSY + HBP;              // 6
    localparam int VST = VSY + VBP;              // 4

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       hs_n, vs_n, r_i, g_i, b_i;
    logic [9:0] pix_x, pix_y;
    logic [2:0] pix_rgb;
    logic       pix_valid, line_start, frame_start, locked, err_hlen, err_vlen;

    vga_rx_capture #(
        .H_VISIBLE (HV),  .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_VISIBLE (VV),  .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .CW        (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .vga_hsync_n (hs_n),
        .vga_vsync_n (vs_n),
        .vga_r       (r_i),
        .vga_g       (g_i),
        .vga_b       (b_i),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .err_hlen    (err_hlen),
        .err_vlen    (err_vlen)
    );

    always #10 clk = ~clk;

    // Output monitor: pulse counters, first/last pixel of a frame, bar edges.
    int         n_valid = 0, n_line = 0, n_frame = 0, n_hlen = 0, n_vlen = 0;
    int         n_pulse = 0, bar_hits = 0, bar_bad = 0, err_lock_bad = 0;
    logic [9:0] first_x = 10'd0, first_y = 10'd0, last_x = 10'd0, last_y = 10'd0;
    logic       want_first = 1'b0;
    logic       locked_prev = 1'b0;

    always @(negedge clk) begin
        locked_prev <= locked;
        n_pulse <= n_pulse + int'(pix_valid) + int'(line_start) + int'(frame_start)
                   + int'(err_hlen) + int'(err_vlen);
        if (line_start)  n_line  <= n_line + 1;
        if (err_hlen)    n_hlen  <= n_hlen + 1;
        if (err_vlen)    n_vlen  <= n_vlen + 1;
        if ((err_hlen || err_vlen) && (locked || !locked_prev)) err_lock_bad <= err_lock_bad + 1;
        if (frame_start) begin
            n_frame    <= n_frame + 1;
            want_first <= 1'b1;
        end
        if (pix_valid) begin
            n_valid <= n_valid + 1;
            last_x  <= pix_x;
            last_y  <= pix_y;
            if (want_first) begin
                first_x    <= pix_x;
                first_y    <= pix_y;
                want_first <= 1'b0;
            end
            if (pix_x == 10'(HV/2 - 1)) begin
                bar_hits <= bar_hits + 1;
                if (pix_rgb !== 3'b101) bar_bad <= bar_bad + 1;
            end
            if (pix_x == 10'(HV/2)) begin
                bar_hits <= bar_hits + 1;
                if (pix_rgb !== 3'b010) bar_bad <= bar_bad + 1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int s_valid, s_line, s_frame, s_hlen, s_vlen, s_bar, s_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One generator pixel: inputs and pix_en set on a negedge, strobe lasts one clk.
    task automatic px(input int v, input int h);
        @(negedge clk);
        hs_n = (h < HSY) ? 1'b0 : 1'b1;
        vs_n = (v < VSY) ? 1'b0 : 1'b1;
        if (h >= HST && h < HST + HV && v >= VST && v < VST + VV)
            {r_i, g_i, b_i} = (h - HST < HV/2) ? 3'b101 : 3'b010;
        else
            {r_i, g_i, b_i} = 3'b000;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic gen_range(input int v, input int h_from, input int h_to);
        for (int h = h_from; h <= h_to; h++) px(v, h);
    endtask

    task automatic gen_lines(input int v_from, input int v_to);
        for (int v = v_from; v <= v_to; v++) gen_range(v, 0, HT - 1);
    endtask

    task automatic snap();
        s_valid = n_valid; s_line = n_line; s_frame = n_frame;
        s_hlen  = n_hlen;  s_vlen = n_vlen; s_bar   = bar_hits;
    endtask

    task automatic check_clean_frame(input string tag);
        check({tag, "_valid"}, n_valid - s_valid, HV * VV);
        check({tag, "_first"}, {first_x, first_y}, {10'd0, 10'd0});
        check({tag, "_last"},  {last_x, last_y}, {10'(HV - 1), 10'(VV - 1)});
        check({tag, "_errs"},  (n_hlen - s_hlen) + (n_vlen - s_vlen), 0);
        check({tag, "_locked"}, locked, 1);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0;
        hs_n = 1'b1; vs_n = 1'b1; r_i = 1'b0; g_i = 1'b0; b_i = 1'b0;
        repeat (200) @(negedge clk);
        check("reset_outputs",
              {pix_x, pix_y, pix_rgb, pix_valid, line_start, frame_start, locked, err_hlen, err_vlen},
              32'd0);
        rst = 1'b0;

        // Join mid-frame, then one full frame: lock happens at its vsync edge.
        gen_lines(5, VT - 1);
        check("pre_lock_locked", locked, 0);
        snap();
        gen_lines(0, VT - 1);
        check("f1_locked", locked, 1);
        check("f1_valid", n_valid - s_valid, HV * VV);
        check("f1_errs", n_hlen + n_vlen, 0);

        // Second nominal frame with colour bars.
        snap();
        gen_lines(0, VT - 1);
        check_clean_frame("f2");
        check("f2_frame_start", n_frame - s_frame, 1);
        check("f2_line_start", n_line - s_line, VT);
        check("f2_bar_hits", bar_hits - s_bar, 2 * VV);

        // One line a pixel short in the middle of the picture.
        snap();
        gen_lines(0, 5);
        gen_range(6, 0, HT - 2);
        gen_lines(7, VT - 1);
        check("short_line_err_hlen", n_hlen - s_hlen, 1);
        check("short_line_valid", n_valid - s_valid, 3 * HV);
        check("short_line_unlocked", locked, 0);
        snap();
        gen_lines(0, VT - 1);
        check_clean_frame("relock_h");

        // A frame one line short is caught at the following vsync edge.
        snap();
        gen_lines(0, VT - 2);
        check("short_frame_valid", n_valid - s_valid, HV * VV);
        snap();
        gen_lines(0, VT - 1);
        check("short_frame_err_vlen", n_vlen - s_vlen, 1);
        check("short_frame_no_pixels", n_valid - s_valid, 0);
        check("short_frame_unlocked", locked, 0);
        snap();
        gen_lines(0, VT - 1);
        check_clean_frame("relock_v");

        // One-clk reset in the middle of visible pixel (3,2).
        gen_lines(0, 5);
        gen_range(6, 0, HST + 3);
        check("pre_rst_locked", locked, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outputs",
              {pix_x, pix_y, pix_rgb, pix_valid, line_start, frame_start, locked, err_hlen, err_vlen},
              32'd0);
        gen_range(6, HST + 4, HT - 1);
        gen_lines(7, VT - 1);
        check("post_rst_unlocked", locked, 0);
        snap();
        gen_lines(0, VT - 1);
        check_clean_frame("relock_rst");

        // Strobe withheld for 50 clk after pixel (1,1).
        snap();
        gen_lines(0, 4);
        gen_range(5, 0, HST + 1);
        @(negedge clk);
        check("hold_before_x", {pix_valid, pix_x, pix_y}, {1'b1, 10'd1, 10'd1});
        @(negedge clk);
        s_pulse = n_pulse;
        repeat (49) @(negedge clk);
        check("hold_no_pulses", n_pulse - s_pulse, 0);
        check("hold_frozen_x", {pix_valid, pix_x, pix_y}, {1'b0, 10'd1, 10'd1});
        px(5, HST + 2);
        @(negedge clk);
        check("hold_next_x", {pix_valid, pix_x, pix_y, pix_rgb}, {1'b1, 10'd2, 10'd1, 3'b101});
        gen_range(5, HST + 3, HT - 1);
        gen_lines(6, VT - 1);
        check("hold_frame_valid", n_valid - s_valid, HV * VV);
        snap();
        gen_lines(0, VT - 1);
        check_clean_frame("after_hold");

        check("bar_colours", bar_bad, 0);
        check("err_lock_timing", err_lock_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rx_capture.md
Name: vga_rx_capture

Overview:
- Receiving end of the 640x480@60 VGA link produced by the team's VGA generator.
- Samples Hsync_n/Vsync_n and 1-bit R/G/B on a pixel strobe and locks to the sync pattern.
- Recovers pixel coordinates, emits a pixel stream with valid/frame/line markers, and flags timing errors.
- Sits in self-checking benches and on-chip loopback; its output feeds a frame checker or capture RAM.

Parameters:
H_VISIBLE 640 visible pixels per line
H_FP 16 horizontal front porch, pixels
H_SYNC 96 hsync pulse width, pixels
H_BP 48 horizontal back porch, pixels
V_VISIBLE 480 visible lines per frame
V_FP 10 vertical front porch, lines
V_SYNC 2 vsync pulse width, lines
V_BP 33 vertical back porch, lines
CW 11 horizontal/vertical counter width

Ports:
clk in 1 system clock
rst in 1 reset
pix_en in 1 pixel strobe, one clk wide (25 MHz rate from 50 MHz clk)
vga_hsync_n in 1 horizontal sync, active low
vga_vsync_n in 1 vertical sync, active low
vga_r in 1 red
vga_g in 1 green
vga_b in 1 blue
pix_x out 10 column of current output pixel, 0..639
pix_y out 10 row of current output pixel, 0..479
pix_rgb out 3 {r,g,b} of current output pixel
pix_valid out 1 one-clk pulse, visible pixel on pix_x/pix_y/pix_rgb
line_start out 1 one-clk pulse on hsync assertion while LOCKED
frame_start out 1 one-clk pulse on vsync assertion while LOCKED
locked out 1 receiver locked to sync pattern
err_hlen out 1 one-clk pulse, line length != H_TOTAL
err_vlen out 1 one-clk pulse, frame length != V_TOTAL

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Derived constants: H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP=800; V_TOTAL=525. H_START=H_SYNC+H_BP=144; V_START=V_SYNC+V_BP=35.
- Reset: all outputs 0; h_cnt=v_cnt=0; state=HSEARCH; input registers loaded with hsync_n=vsync_n=1, rgb=0.
- All logic advances only on clk cycles with pix_en=1. Cycles with pix_en=0 hold all state, and every pulse output is 0.
- Stage 1: register the inputs. Sync assertion edge = previous registered value 1, new value 0.
- Stage 2: counters, FSM and registered outputs. Latency is 2 clk from the pix_en cycle that sampled a pixel to its pix_valid pulse.
- Horizontal counter: h_cnt<=0 on an hsync edge, else h_cnt+1, saturating at 2^CW-1.
- Vertical counter: advances only on hsync edges. v_cnt<=0 when a vsync edge is seen on the same or a preceding line within the sync pulse, else v_cnt+1, saturating at 2^CW-1.
- Length checks:
  - On an hsync edge in VSEARCH or LOCKED: line length = h_cnt+1. If it differs from H_TOTAL, pulse err_hlen.
  - On a vsync edge in LOCKED: frame length = v_cnt+1. If it differs from V_TOTAL, pulse err_vlen.
- FSM:
  - HSEARCH -> VSEARCH on first hsync edge.
  - VSEARCH -> LOCKED on first vsync edge, provided the last line length was correct. Any err_hlen in VSEARCH -> HSEARCH.
  - LOCKED -> HSEARCH on err_hlen or err_vlen; locked drops the same cycle the error pulse asserts.
  - Reset in any state -> HSEARCH on the next clk.
- Pixel output: pix_valid=1 only when LOCKED, h_cnt in [H_START, H_START+H_VISIBLE-1] and v_cnt in [V_START, V_START+V_VISIBLE-1].
  - Then pix_x=h_cnt-H_START and pix_y=v_cnt-V_START (truncated to 10 bits), and pix_rgb is the registered RGB.
  - When pix_valid=0, pix_x/pix_y/pix_rgb hold their last value.
- Simultaneous hsync and vsync edges (normal at frame start): process the vsync edge first.
  - v_cnt=0; frame_start and line_start both pulse.
- A sync held low for longer than its width is not re-counted as an edge. Glitch-free sync is the sender's responsibility; there is no filtering.

Decomposition:
- Package vga_timing_pkg: the 640x480@60 timing constants, derived H_TOTAL/V_TOTAL/H_START/V_START, and FSM state encoding (HSEARCH, VSEARCH, LOCKED). Shared with the generator and the frame checker.
- One sub-module, vga_sync_edge: registers one sync input on pix_en and emits the assertion-edge pulse. Instantiated twice.

Test Plan:
- Reset held 200 clk, then a nominal generator frame with pix_en every other clk:
  - locked=1 after the first vsync edge, no error pulses;
  - exactly 307200 pix_valid pulses in the second frame;
  - first pulse at (0,0), last at (639,479).
- Generator driving a vertical colour-bar pattern (rgb=sw-style 3'b101 for x<320, 3'b010 otherwise):
  - pix_rgb at x=319 is 101 and at x=320 is 010, every row.
- Inject one 799-pixel line mid-frame:
  - err_hlen pulses once and locked drops the same clk;
  - relock (locked=1) at the next vsync edge, pixels resume at (0,0).
- Frame of 524 lines: err_vlen pulse at the vsync edge, locked=0, relock one frame later.
- Assert rst for 1 clk mid-line at (300,200): next clk all outputs 0 and state HSEARCH; relock at the following vsync.
- pix_en held 0 for 50 clk mid-line: no pulses, counters frozen, the next pixel is x+1.
